// File: rtl/kinase_pkg.sv
// Shared encodings for the kinase-activity chip sequencer: command ops,
// sequencer states and the pump phase patterns.
package kinase_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_PUMP  = 2'd1,
        OP_MIX   = 2'd2,
        OP_FLUSH = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_PUMP,
        ST_MIX,
        ST_FLUSH
    } state_e;

    localparam int PUMP_A_STEPS = 6;
    localparam int PUMP_B_STEPS = 2;

    // Element [0] is the first phase of a rotation.
    localparam logic [PUMP_A_STEPS-1:0][2:0] PUMP_A_SEQ =
        {3'b010, 3'b110, 3'b100, 3'b101, 3'b001, 3'b011};
    localparam logic [PUMP_B_STEPS-1:0][1:0] PUMP_B_SEQ =
        {2'b10, 2'b01};

endpackage

// File: rtl/kinase_step_timer.sv
// Loadable down-counter; tick marks the last cycle of a period and the
// counter wraps back to load_val so consecutive periods run seamlessly.
module kinase_step_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         tick
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= (count == '0) ? load_val : count - W'(1);
        end
    end

    assign tick = en & (count == '0);

endmodule

// File: rtl/kinase_seq_ctrl.sv
// Assay command sequencer: settles, pumps, mixes or flushes the chip and
// drives the padded valve, selector, pump and flush control lines.
module kinase_seq_ctrl
    import kinase_pkg::*;
#(
    parameter int CHANNELS     = 3,
    parameter int N_VALVE      = 13,
    parameter int N_SEL        = 4,
    parameter int N_PUMP_B     = 2,
    parameter int STEP_CYCLES  = 16,
    parameter int FLUSH_CYCLES = 64,
    parameter int CNT_W        = 16,
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [CW-1:0]       cmd_chan,
    input  logic [CNT_W-1:0]    cmd_count,
    input  logic [N_VALVE-1:0]  cmd_valves,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [N_VALVE-1:0]  ctrl_a,
    output logic [N_SEL-1:0]    ctrl_s,
    output logic [2:0]          pump_a,
    output logic [N_PUMP_B-1:0] pump_b,
    output logic [N_VALVE-1:0]  flush_ctrl_a,
    output logic [N_SEL-1:0]    flush_ctrl_s,
    output logic [2:0]          flush_pump_a,
    output logic [N_PUMP_B-1:0] flush_pump_b
);

    localparam int MAX_CYC = (STEP_CYCLES > FLUSH_CYCLES) ? STEP_CYCLES : FLUSH_CYCLES;
    localparam int TW      = $clog2(MAX_CYC) + 1;

    state_e             state;
    op_e                op_q;
    op_e                cmd_op_e;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   rot;
    logic [2:0]         step;
    logic [2:0]         pa_next;
    logic [2:0]         mx_next;
    logic               accept;
    logic               bad_cmd;
    logic               last_rot;
    logic               finish;
    logic               kill;
    logic               tick;
    logic               tmr_en;
    logic [TW-1:0]      tmr_val;

    // Handshake: a command transfers on a cycle where cmd_valid and cmd_ready
    // are both high; cmd_ready is only offered while idle and abort is low.
    assign cmd_ready = (state == ST_IDLE) & ~abort;
    assign accept    = cmd_valid & cmd_ready;
    assign cmd_op_e  = op_e'(cmd_op);
    assign bad_cmd   = ({1'b0, cmd_chan} >= (CW+1)'(CHANNELS)) || (cmd_count == '0);

    assign pa_next  = (step == 3'd5) ? 3'd0 : step + 3'd1;
    assign mx_next  = (step == 3'd1) ? 3'd0 : 3'd1;
    assign last_rot = (rot == cnt_q - CNT_W'(1));

    // The flush period is selected at accept time and while flushing; all
    // other phases share the step period.
    assign tmr_val = ((state == ST_IDLE && cmd_op_e == OP_FLUSH) || state == ST_FLUSH)
                   ? TW'(FLUSH_CYCLES - 1) : TW'(STEP_CYCLES - 1);
    assign tmr_en  = (state != ST_IDLE) & ~abort;

    kinase_step_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .en       (tmr_en),
        .load_val (tmr_val),
        .tick     (tick)
    );

    assign kill   = abort & (state != ST_IDLE);
    assign finish = ~abort & tick &
                    ((state == ST_FLUSH) ||
                     (state == ST_PUMP && step == 3'd5 && last_rot) ||
                     (state == ST_MIX  && step == 3'd1 && last_rot));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            op_q         <= OP_NOP;
            cnt_q        <= '0;
            rot          <= '0;
            step         <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            ctrl_a       <= '0;
            ctrl_s       <= '0;
            pump_a       <= '0;
            pump_b       <= '0;
            flush_ctrl_a <= '0;
            flush_ctrl_s <= '0;
            flush_pump_a <= '0;
            flush_pump_b <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (kill || finish) begin
                // Abort and normal completion both drop every line at once;
                // only a normal completion reports done.
                state        <= ST_IDLE;
                busy         <= 1'b0;
                done         <= finish;
                ctrl_a       <= '0;
                ctrl_s       <= '0;
                pump_a       <= '0;
                pump_b       <= '0;
                flush_ctrl_a <= '0;
                flush_ctrl_s <= '0;
                flush_pump_a <= '0;
                flush_pump_b <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (accept) begin
                            unique case (cmd_op_e)
                                OP_NOP: done <= 1'b1;
                                OP_PUMP, OP_MIX: begin
                                    if (bad_cmd) begin
                                        err <= 1'b1;
                                    end else begin
                                        state  <= ST_SETTLE;
                                        busy   <= 1'b1;
                                        op_q   <= cmd_op_e;
                                        cnt_q  <= cmd_count;
                                        rot    <= '0;
                                        step   <= '0;
                                        ctrl_a <= cmd_valves;
                                        ctrl_s <= N_SEL'(1) << cmd_chan;
                                    end
                                end
                                OP_FLUSH: begin
                                    state        <= ST_FLUSH;
                                    busy         <= 1'b1;
                                    op_q         <= OP_FLUSH;
                                    ctrl_s       <= {1'b1, {(N_SEL-1){1'b0}}};
                                    flush_ctrl_a <= '1;
                                    flush_ctrl_s <= '1;
                                    flush_pump_a <= '1;
                                    flush_pump_b <= '1;
                                end
                            endcase
                        end
                    end
                    ST_SETTLE: begin
                        if (tick) begin
                            step <= '0;
                            if (op_q == OP_PUMP) begin
                                state  <= ST_PUMP;
                                pump_a <= PUMP_A_SEQ[0];
                            end else begin
                                state  <= ST_MIX;
                                pump_b <= PUMP_B_SEQ[0];
                            end
                        end
                    end
                    ST_PUMP: begin
                        if (tick) begin
                            step   <= pa_next;
                            pump_a <= PUMP_A_SEQ[pa_next];
                            if (step == 3'd5) rot <= rot + CNT_W'(1);
                        end
                    end
                    ST_MIX: begin
                        if (tick) begin
                            step   <= mx_next;
                            pump_b <= PUMP_B_SEQ[mx_next[0]];
                            if (step == 3'd1) rot <= rot + CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
